// File: rtl/program_counter_register.sv
// Program counter register: holds the current instruction address for fetch.
// The next address is computed upstream; this block only captures it.
//
// Ports:
//   clk      - system clock, all updates on rising edge
//   rst      - synchronous active-high reset, loads RESET_ADDR
//   pc_en    - load enable, captures addr_in on the rising edge when high
//   addr_in  - next PC value from fetch/branch logic
//   addr_out - current PC, driven straight from the register
module program_counter_register #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] addr_out
);

  // Boot address truncated to the address width; callers keep it in range.
  localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_ADDR);

  logic [ADDR_W-1:0] pc_q;

  // PC flop: reset has priority over the load enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else if (pc_en) begin
      pc_q <= addr_in;
    end
  end

  assign addr_out = pc_q;

endmodule

// File: tb/tb_program_counter_register.sv
// Directed bench for program_counter_register at default width.
module tb_program_counter_register;

  localparam int unsigned ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic              pc_en;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] addr_out;

  int checks;
  int errors;

  program_counter_register #(
    .ADDR_W    (ADDR_W),
    .RESET_ADDR(0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pc_en   (pc_en),
    .addr_in (addr_in),
    .addr_out(addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ADDR_W-1:0] exp);
    checks++;
    assert (addr_out === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, addr_out, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle past the edge.
  task automatic step(input logic r, input logic e, input logic [ADDR_W-1:0] a);
    rst     = r;
    pc_en   = e;
    addr_in = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    pc_en   = 1'b1;
    addr_in = 6'd5;

    // Reset wins over enable, across two edges.
    step(1'b1, 1'b1, 6'd5);  check("reset_edge1", 6'd0);
    step(1'b1, 1'b1, 6'd5);  check("reset_edge2", 6'd0);

    // Load sequence right after reset release.
    step(1'b0, 1'b1, 6'd1);  check("load_1", 6'd1);
    step(1'b0, 1'b1, 6'd2);  check("load_2", 6'd2);
    step(1'b0, 1'b1, 6'd3);  check("load_3", 6'd3);

    // Hold while addr_in wanders.
    step(1'b0, 1'b0, 6'd4);  check("hold_4", 6'd3);
    step(1'b0, 1'b0, 6'd9);  check("hold_9", 6'd3);
    step(1'b0, 1'b0, 6'd63); check("hold_63", 6'd3);

    // Single-edge enable, then low.
    step(1'b0, 1'b1, 6'd7);  check("en_pulse_load", 6'd7);
    step(1'b0, 1'b0, 6'd8);  check("en_pulse_hold1", 6'd7);

    // Enable pulse entirely between edges is ignored.
    pc_en   = 1'b1;
    addr_in = 6'd20;
    #2;
    check("mid_cycle_no_comb_path", 6'd7);
    pc_en   = 1'b0;
    addr_in = 6'd8;
    @(posedge clk);
    #1;
    check("glitch_en_ignored", 6'd7);

    // Boundary values.
    step(1'b0, 1'b1, 6'd63); check("load_max", 6'd63);
    step(1'b0, 1'b1, 6'd0);  check("load_zero", 6'd0);

    // Reset mid-run; asserting between edges does nothing until the edge.
    step(1'b0, 1'b1, 6'd42); check("load_42", 6'd42);
    rst     = 1'b1;
    pc_en   = 1'b1;
    addr_in = 6'd10;
    #2;
    check("rst_async_no_effect", 6'd42);
    @(posedge clk);
    #1;
    check("rst_mid_run", 6'd0);
    step(1'b0, 1'b1, 6'd10); check("rst_release_load", 6'd10);

    // Consecutive enables load every edge.
    step(1'b0, 1'b1, 6'd33); check("consec_33", 6'd33);
    step(1'b0, 1'b1, 6'd21); check("consec_21", 6'd21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
